// File: rtl/vc_val_rdy_pipe_reg_if.sv
// Val/rdy handshake bundle for elastic pipeline ports.
// Master drives val/msg, slave answers with rdy.
interface vc_val_rdy_pipe_reg_if #(
  parameter int p_nbits = 32
);
  logic               val;
  logic               rdy;
  logic [p_nbits-1:0] msg;

  modport master (
    output val,
    output msg,
    input  rdy
  );

  modport slave (
    input  val,
    input  msg,
    output rdy
  );
endinterface

// File: rtl/vc_val_rdy_pipe_reg.sv
// Stallable N-deep val/rdy register chain with flush.
// Bubbles collapse so a stalled output lets upstream fill.
module vc_val_rdy_pipe_reg #(
  parameter int               p_nbits       = 32,
  parameter int               p_nstages     = 2,
  parameter logic [p_nbits-1:0] p_reset_value = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  vc_val_rdy_pipe_reg_if.slave   enq,
  vc_val_rdy_pipe_reg_if.master  deq,
  output logic [$clog2(p_nstages+1)-1:0] count
);

  localparam int CW = $clog2(p_nstages + 1);

  logic [p_nstages-1:0] val_q;
  logic [p_nbits-1:0]   data_q [p_nstages];
  logic [p_nstages-1:0] go;
  logic [p_nstages-1:0] ld;

  // Walk from the output side so each stage sees
  // whether its downstream neighbour frees up.
  always_comb begin
    logic down_ld;
    go      = '0;
    ld      = '0;
    down_ld = deq.rdy;
    for (int i = p_nstages - 1; i >= 0; i--) begin
      go[i]   = val_q[i] & down_ld;
      ld[i]   = !val_q[i] | go[i];
      down_ld = ld[i];
    end
  end

  assign enq.rdy = ld[0] & !flush & !reset;
  assign deq.val = val_q[p_nstages-1];
  assign deq.msg = data_q[p_nstages-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
      for (int i = 0; i < p_nstages; i++)
        data_q[i] <= p_reset_value;
    end else if (flush) begin
      val_q <= '0;
    end else begin
      if (ld[0]) begin
        val_q[0] <= enq.val;
        if (enq.val)
          data_q[0] <= enq.msg;
      end
      // Bubbles move forward but never overwrite data.
      for (int i = 1; i < p_nstages; i++) begin
        if (ld[i]) begin
          val_q[i] <= val_q[i-1];
          if (val_q[i-1])
            data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < p_nstages; i++)
      count = count + CW'(val_q[i]);
  end

  a_ctrl_known: assert property (
    @(posedge clk) disable iff (reset)
    !$isunknown({enq.val, deq.rdy, flush})
  );

endmodule

// File: tb/tb_vc_val_rdy_pipe_reg.sv
// Directed and scoreboard bench for vc_val_rdy_pipe_reg.
// Covers N=1..5 with reset, stall, flush and random traffic.
module tb_vc_val_rdy_pipe_reg;

  localparam logic [31:0] RV = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic       rnd_go = 1'b0;
  logic [1:0] rnd_done = 2'b00;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          rst, fl, ev;
    logic [31:0] em;
    int          dr, er, dv;
    logic [31:0] dm;
    int          cnt;
  } vec_t;

  function automatic vec_t mk(int rst, int fl, int ev,
                              logic [31:0] em, int dr, int er,
                              int dv, logic [31:0] dm, int cnt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.ev = ev; v.em = em; v.dr = dr;
    v.er = er; v.dv = dv; v.dm = dm; v.cnt = cnt;
    return v;
  endfunction

  // N=2, reset value RV: table-driven
  logic       a_rst, a_fl;
  logic [1:0] a_cnt;
  vc_val_rdy_pipe_reg_if #(.p_nbits(32)) a_enq (), a_deq ();
  vc_val_rdy_pipe_reg #(
    .p_nbits(32), .p_nstages(2), .p_reset_value(RV)
  ) u_a (
    .clk(clk), .reset(a_rst), .flush(a_fl),
    .enq(a_enq), .deq(a_deq), .count(a_cnt)
  );

  // N=3 streaming
  logic       b_rst, b_fl;
  logic [1:0] b_cnt;
  vc_val_rdy_pipe_reg_if #(.p_nbits(32)) b_enq (), b_deq ();
  vc_val_rdy_pipe_reg #(
    .p_nbits(32), .p_nstages(3), .p_reset_value(32'h0)
  ) u_b (
    .clk(clk), .reset(b_rst), .flush(b_fl),
    .enq(b_enq), .deq(b_deq), .count(b_cnt)
  );

  // N=4 flush
  logic       c_rst, c_fl;
  logic [2:0] c_cnt;
  vc_val_rdy_pipe_reg_if #(.p_nbits(32)) c_enq (), c_deq ();
  vc_val_rdy_pipe_reg #(
    .p_nbits(32), .p_nstages(4), .p_reset_value(32'h0)
  ) u_c (
    .clk(clk), .reset(c_rst), .flush(c_fl),
    .enq(c_enq), .deq(c_deq), .count(c_cnt)
  );

  // N=1 and N=5 random traffic against a queue model
  for (genvar g = 0; g < 2; g++) begin : g_rnd
    localparam int N  = (g == 0) ? 1 : 5;
    localparam int CW = $clog2(N + 1);
    logic          rs;
    logic [CW-1:0] cnt;
    vc_val_rdy_pipe_reg_if #(.p_nbits(32)) e (), d ();
    vc_val_rdy_pipe_reg #(
      .p_nbits(32), .p_nstages(N), .p_reset_value(32'h0)
    ) u_r (
      .clk(clk), .reset(rs), .flush(1'b0),
      .enq(e), .deq(d), .count(cnt)
    );

    initial begin
      logic [31:0] q[$];
      logic        xr, eh, dh;
      rs = 1'b1; e.val = 1'b0; e.msg = '0; d.rdy = 1'b0;
      wait (rnd_go);
      @(posedge clk);
      @(posedge clk);
      #1 rs = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        e.val = 1'($urandom_range(1, 0));
        e.msg = $urandom;
        d.rdy = 1'($urandom_range(1, 0));
        @(negedge clk);
        chk($sformatf("rnd%0d_cnt_c%0d", N, c),
            32'(cnt), 32'(q.size()));
        xr = (q.size() < N) || d.rdy;
        chk($sformatf("rnd%0d_enq_rdy_c%0d", N, c),
            32'(e.rdy), 32'(xr));
        if (q.size() == 0)
          chk($sformatf("rnd%0d_deq_val_c%0d", N, c),
              32'(d.val), 32'(0));
        eh = e.val & e.rdy;
        dh = d.val & d.rdy;
        if (dh && q.size() != 0)
          chk($sformatf("rnd%0d_deq_msg_c%0d", N, c),
              d.msg, q.pop_front());
        if (eh)
          q.push_back(e.msg);
        @(posedge clk);
        #1;
      end
      rnd_done[g] = 1'b1;
    end
  end

  vec_t tbl [19];

  initial begin
    int enq_n, deq_n;
    logic xdv;

    a_rst = 1'b1; a_fl = 1'b0;
    a_enq.val = 1'b1; a_enq.msg = 32'h11; a_deq.rdy = 1'b0;
    b_rst = 1'b1; b_fl = 1'b0;
    b_enq.val = 1'b0; b_enq.msg = '0; b_deq.rdy = 1'b0;
    c_rst = 1'b1; c_fl = 1'b0;
    c_enq.val = 1'b0; c_enq.msg = '0; c_deq.rdy = 1'b0;

    //           rst fl ev em     dr  er dv dm     cnt
    tbl[0]  = mk(1, 0, 1, 32'h11, 0,  0, 0, RV,    0);
    tbl[1]  = mk(0, 0, 0, 32'h0,  0,  1, 0, RV,    0);
    tbl[2]  = mk(0, 0, 1, 32'h7,  0,  1, 0, RV,    0);
    tbl[3]  = mk(0, 0, 1, 32'h8,  0,  1, 0, RV,    1);
    tbl[4]  = mk(0, 0, 1, 32'h9,  0,  0, 1, 32'h7, 2);
    tbl[5]  = mk(0, 0, 1, 32'h9,  0,  0, 1, 32'h7, 2);
    tbl[6]  = mk(0, 0, 1, 32'h9,  1,  1, 1, 32'h7, 2);
    tbl[7]  = mk(0, 0, 0, 32'h0,  1,  1, 1, 32'h8, 2);
    tbl[8]  = mk(0, 0, 0, 32'h0,  1,  1, 1, 32'h9, 1);
    tbl[9]  = mk(0, 0, 0, 32'h0,  1,  1, 0, 32'h9, 0);
    tbl[10] = mk(0, 0, 1, 32'h1,  0,  1, 0, 32'h9, 0);
    tbl[11] = mk(0, 0, 1, 32'h2,  0,  1, 0, 32'h9, 1);
    tbl[12] = mk(0, 0, 1, 32'h3,  1,  1, 1, 32'h1, 2);
    tbl[13] = mk(0, 0, 0, 32'h0,  0,  0, 1, 32'h2, 2);
    tbl[14] = mk(0, 1, 1, 32'h4,  1,  0, 1, 32'h2, 2);
    tbl[15] = mk(0, 0, 0, 32'h0,  1,  1, 0, 32'h2, 0);
    tbl[16] = mk(0, 0, 1, 32'h5,  0,  1, 0, 32'h2, 0);
    tbl[17] = mk(1, 0, 1, 32'h6,  0,  0, 0, 32'h2, 1);
    tbl[18] = mk(0, 0, 0, 32'h0,  0,  1, 0, RV,    0);

    for (int i = 0; i < 19; i++) begin
      @(posedge clk);
      #1;
      a_rst     = (tbl[i].rst != 0);
      a_fl      = (tbl[i].fl != 0);
      a_enq.val = (tbl[i].ev != 0);
      a_enq.msg = tbl[i].em;
      a_deq.rdy = (tbl[i].dr != 0);
      @(negedge clk);
      chk($sformatf("vec%0d_enq_rdy", i),
          32'(a_enq.rdy), 32'(tbl[i].er));
      chk($sformatf("vec%0d_deq_val", i),
          32'(a_deq.val), 32'(tbl[i].dv));
      chk($sformatf("vec%0d_deq_msg", i),
          a_deq.msg, tbl[i].dm);
      chk($sformatf("vec%0d_count", i),
          32'(a_cnt), 32'(tbl[i].cnt));
    end

    @(posedge clk);
    #1 b_rst = 1'b0; c_rst = 1'b0;

    // N=3: 1..10 back to back, output lags by 3 cycles
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      b_enq.val = (c < 10);
      b_enq.msg = 32'(c + 1);
      b_deq.rdy = 1'b1;
      @(negedge clk);
      enq_n = (c < 10) ? c : 10;
      deq_n = (c < 3) ? 0 : ((c - 3 > 10) ? 10 : c - 3);
      xdv   = (c >= 3) && (c < 13);
      chk($sformatf("stream_enq_rdy_c%0d", c),
          32'(b_enq.rdy), 32'(1));
      chk($sformatf("stream_deq_val_c%0d", c),
          32'(b_deq.val), 32'(xdv));
      if (xdv)
        chk($sformatf("stream_deq_msg_c%0d", c),
            b_deq.msg, 32'(c - 2));
      chk($sformatf("stream_count_c%0d", c),
          32'(b_cnt), 32'(enq_n - deq_n));
    end

    // N=4: fill, flush with an offered item, then refill
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      c_enq.val = 1'b1;
      c_enq.msg = 32'(c + 1);
      c_deq.rdy = 1'b0;
      @(negedge clk);
      chk($sformatf("fill_enq_rdy_c%0d", c),
          32'(c_enq.rdy), 32'(1));
    end
    @(posedge clk);
    #1 c_fl = 1'b1; c_enq.val = 1'b1; c_enq.msg = 32'h5;
    @(negedge clk);
    chk("flush_full_count", 32'(c_cnt), 32'(4));
    chk("flush_full_deq_val", 32'(c_deq.val), 32'(1));
    chk("flush_full_deq_msg", c_deq.msg, 32'h1);
    chk("flush_enq_rdy", 32'(c_enq.rdy), 32'(0));
    @(posedge clk);
    #1 c_fl = 1'b0; c_enq.val = 1'b0;
    @(negedge clk);
    chk("post_flush_count", 32'(c_cnt), 32'(0));
    chk("post_flush_deq_val", 32'(c_deq.val), 32'(0));
    @(posedge clk);
    #1 c_enq.val = 1'b1; c_enq.msg = 32'h6; c_deq.rdy = 1'b1;
    @(negedge clk);
    chk("refill_enq_rdy", 32'(c_enq.rdy), 32'(1));
    for (int j = 1; j < 7; j++) begin
      @(posedge clk);
      #1 c_enq.val = 1'b0;
      @(negedge clk);
      chk($sformatf("refill_deq_val_j%0d", j),
          32'(c_deq.val), 32'(j == 4));
      chk($sformatf("refill_count_j%0d", j),
          32'(c_cnt), 32'(j <= 4));
      if (j == 4)
        chk("refill_deq_msg", c_deq.msg, 32'h6);
    end

    rnd_go = 1'b1;
    for (int t = 0; t < 3000 && rnd_done != 2'b11; t++)
      @(posedge clk);
    chk("rnd_done", 32'(rnd_done), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_val_rdy_pipe_reg.md
# vc_val_rdy_pipe_reg

Parametrised multi-stage elastic pipeline register with a val/rdy handshake on both sides, configurable data width, stage count and data reset value, plus a synchronous flush. It generalises the single enable/reset register into a stallable N-deep register chain. It is dropped between cache pipeline stages (tag, data, coherence-message paths) wherever timing must be cut without losing back-pressure.

## Interface
- p_nbits, 32, data width in bits (>=1)
- p_nstages, 2, number of register stages (>=1)
- p_reset_value, 0, value loaded into every data register on reset (p_nbits wide)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset, sampled on rising edge of clk
- flush  in  1  synchronous clear of all stage valid bits
- enq_val  in  1  upstream has data
- enq_rdy  out  1  block accepts data this cycle
- enq_msg  in  p_nbits  upstream data
- deq_val  out  1  last stage holds valid data
- deq_rdy  in  1  downstream accepts data this cycle
- deq_msg  out  p_nbits  last stage data
- count  out  $clog2(p_nstages+1)  number of valid stages

## Operation
- State per stage i (0 = input side, p_nstages-1 = output side): val[i] (1 bit), data[i] (p_nbits).
- Advance terms, computed combinationally from the output side backwards:
  - go[N-1] = deq_val & deq_rdy.
  - stage i can load: ld[i] = !val[i] | go[i].
  - go[i] (i<N-1) = val[i] & ld[i+1].
- enq_rdy = ld[0] & !flush & !reset. Transfer in when enq_val & enq_rdy; transfer out when deq_val & deq_rdy.
- Per cycle, priority reset > flush > normal:
  - reset: all val <= 0, all data <= p_reset_value.
  - flush: all val <= 0; data registers hold; a dequeue completing this cycle still counts as taken by the consumer, and an enqueue is not accepted.
  - normal: stage 0 loads enq_msg with val <= enq_val when ld[0]; stage i>0 loads data[i-1] with val <= val[i-1] when ld[i]; data registers write only when their stage loads and the incoming val is 1 (bubbles do not overwrite data).
- deq_msg = data[N-1] regardless of deq_val; deq_val = val[N-1].
- count = popcount(val); registered state only, no combinational dependence on handshakes.
- Bubbles collapse: a stalled output lets upstream stages fill until all N are valid, then enq_rdy drops.
- No combinational path enq_val -> enq_rdy. deq_rdy -> enq_rdy is combinational through the chain (full-throughput design).
- Assertions (not under reset): enq_val, deq_rdy, flush not X.

## Timing
- Reset values: deq_val=0, deq_msg=p_reset_value, count=0; enq_rdy=0 while reset high, 1 the cycle after (if flush low).
- Latency: item accepted at edge k appears on deq_msg with deq_val=1 after edge k+p_nstages-1 (visible in cycle k+p_nstages-1...), i.e. exactly p_nstages cycles from enq handshake cycle to earliest deq handshake cycle, with deq_rdy held high.
- Throughput: 1 item/cycle sustained with deq_rdy high, including the full case with simultaneous enq and deq.
- Full (count==N) with deq_rdy=0: enq_rdy=0, contents and deq_msg stable.
- Full with deq_rdy=1: enq_rdy=1, enq and deq in same cycle, count stays N.
- Empty: deq_val=0; enq in same cycle is not visible at deq until latency elapses (no bypass).
- Reset or flush mid-stream: all in-flight items discarded at that edge; next cycle count=0.

## Test plan
- Reset: hold reset 2 cycles with enq_val=1, p_reset_value=32'hA5A5_0000 -> deq_val=0, deq_msg=32'hA5A5_0000, count=0, enq_rdy=0 during reset, 1 after.
- Streaming, N=3: enqueue 1..10 on consecutive cycles, deq_rdy=1 -> deq yields 1..10 on 10 consecutive cycles, first 3 cycles after first enq, count steady 3.
- Back-pressure: N=2, deq_rdy=0, enqueue 7,8,9 -> 7,8 accepted, enq_rdy=0 when offering 9, count=2; raise deq_rdy -> 7 then 8 then 9 in order, nothing lost or duplicated.
- Full simultaneous enq/deq: N=2 full with 1,2, deq_rdy=1, enq 3 same cycle -> 1 dequeued, 3 accepted, count stays 2.
- Flush: N=4 holding 4 items, assert flush with enq_val=1 msg 5 -> next cycle count=0, deq_val=0, 5 not accepted; enqueue 6 afterwards -> 6 emerges 4 cycles later.
- Random stall: random enq_val/deq_rdy (50%) for 1000 cycles, N=1 and N=5 -> scoreboard order matches, count equals in-flight model every cycle.
